// File: rtl/demorgan_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : demorgan_sweep_checker
// Description : On-chip self-test for the four De Morgan gate circuits. Sweeps
//               the 2-input truth table on a_out/b_out, samples the circuit
//               outputs after a settle time, and accumulates a saturating
//               mismatch count plus a per-vector failure map.
// Revision    : 1.0 - initial release
// ============================================================================
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             nAandnB_in,
  input  logic             nAandB_in,
  input  logic             nAornB_in,
  input  logic             nAorB_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  // Settle counter only needs to reach SETTLE_CYCLES-1; it never runs past it.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // Extra headroom so err_count + 4 can never wrap before the clamp.
  localparam int SUM_W = ERR_W + 3;
  localparam logic [SUM_W-1:0] C_ERR_MAX = SUM_W'((2 ** ERR_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [1:0]       vec, vec_n;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_n;
  logic             a_n, b_n, busy_n, done_n, pass_n;
  logic [ERR_W-1:0] err_n;
  logic [3:0]       fail_n;

  logic       golden_nor;
  logic       golden_nand;
  logic [3:0] miss;
  logic [2:0] miss_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  // Golden responses and saturating mismatch accumulation for the current vector.
  always_comb begin
    golden_nor  = ~(vec[1] | vec[0]);
    golden_nand = ~(vec[1] & vec[0]);
    miss[0]     = nAandnB_in ^ golden_nor;
    miss[1]     = nAandB_in  ^ golden_nand;
    miss[2]     = nAornB_in  ^ golden_nand;
    miss[3]     = nAorB_in   ^ golden_nor;
    miss_cnt    = {2'b00, miss[0]} + {2'b00, miss[1]} + {2'b00, miss[2]} + {2'b00, miss[3]};
    err_sum     = {3'b000, err_count} + SUM_W'(miss_cnt);
    err_sat     = (err_sum > C_ERR_MAX) ? C_ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_n      = state;
    vec_n        = vec;
    settle_cnt_n = settle_cnt;
    a_n          = a_out;
    b_n          = b_out;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_n        = err_count;
    fail_n       = fail_vec;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n      = S_DRIVE;
          vec_n        = 2'd0;
          settle_cnt_n = '0;
          a_n          = 1'b0;
          b_n          = 1'b0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_n        = '0;
          fail_n       = 4'b0000;
        end
      end
      S_DRIVE: begin
        if (settle_cnt == C_CNT_LAST) begin
          state_n = S_SAMPLE;
        end else begin
          settle_cnt_n = settle_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        err_n       = err_sat;
        fail_n[vec] = fail_vec[vec] | (|miss);
        if (vec == 2'd3) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_sat == '0);
        end else begin
          state_n      = S_DRIVE;
          vec_n        = vec + 2'd1;
          settle_cnt_n = '0;
          a_n          = vec_n[1];
          b_n          = vec_n[0];
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= 2'd0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= 4'b0000;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      settle_cnt <= settle_cnt_n;
      a_out      <= a_n;
      b_out      <= b_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_n;
      fail_vec   <= fail_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demorgan_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_demorgan_sweep_checker
// Description : Directed bench for demorgan_sweep_checker with a sweep-level
//               reference model and literal expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demorgan_sweep_checker;

  localparam int P = 3;  // SETTLE_CYCLES + 1 cycles per vector

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic a1, b1, busy1, done1, pass1;
  logic a2, b2, busy2, done2, pass2;
  logic [4:0] err1;
  logic [1:0] err2;
  logic [3:0] fv1, fv2;
  logic f1_0, f1_1, f1_2, f1_3, f2_0, f2_1, f2_2, f2_3;

  // Fault mode per circuit output: 0 ideal, 1 stuck-at-0, 2 inverted.
  // Index: 0 nAandnB, 1 nAandB, 2 nAornB, 3 nAorB.
  int fm [4];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic apply_fault(int mode, logic g);
    if (mode == 1) return 1'b0;
    if (mode == 2) return ~g;
    return g;
  endfunction

  // Circuits under test, built from their own names, with faults applied.
  assign f1_0 = apply_fault(fm[0], (~a1) & (~b1));
  assign f1_1 = apply_fault(fm[1], ~(a1 & b1));
  assign f1_2 = apply_fault(fm[2], (~a1) | (~b1));
  assign f1_3 = apply_fault(fm[3], ~(a1 | b1));
  assign f2_0 = apply_fault(fm[0], (~a2) & (~b2));
  assign f2_1 = apply_fault(fm[1], ~(a2 & b2));
  assign f2_2 = apply_fault(fm[2], (~a2) | (~b2));
  assign f2_3 = apply_fault(fm[3], ~(a2 | b2));

  demorgan_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
    .nAandnB_in(f1_0), .nAandB_in(f1_1), .nAornB_in(f1_2), .nAorB_in(f1_3),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a_out(a2), .b_out(b2),
    .nAandnB_in(f2_0), .nAandB_in(f2_1), .nAornB_in(f2_2), .nAorB_in(f2_3),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit mact = 1'b0;
  bit mdone = 1'b0;
  int mk = 0;
  int mfm [4];

  // Number of wrong outputs a sweep sees at vector v, from the truth table.
  function automatic int vec_errs(int v);
    int a, b, cnt;
    int g [4];
    int o;
    a = (v >> 1) & 1;
    b = v & 1;
    g[0] = (a == 0 && b == 0) ? 1 : 0;  // ~(A|B)
    g[1] = (a == 1 && b == 1) ? 0 : 1;  // ~(A&B)
    g[2] = g[1];
    g[3] = g[0];
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      o = (mfm[i] == 1) ? 0 : (mfm[i] == 2) ? 1 - g[i] : g[i];
      if (o != g[i]) cnt++;
    end
    return cnt;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mact = 1'b0;
      mdone = 1'b0;
      mk = 0;
    end else if (start && !mact) begin
      mact = 1'b1;
      mdone = 1'b0;
      mk = 0;
      for (int i = 0; i < 4; i++) mfm[i] = fm[i];
    end else if (mact) begin
      mk++;
      if (mk == 4 * P) begin
        mact = 1'b0;
        mdone = 1'b1;
      end
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    int nv, v, sum, e1, e2, efv, ea, eb;
    if (chk_en) begin
      v  = mact ? mk / P : 0;
      ea = mdone ? 1 : (mact ? (v >> 1) & 1 : 0);
      eb = mdone ? 1 : (mact ? v & 1 : 0);
      nv = mdone ? 4 : (mact ? mk / P : 0);
      sum = 0;
      efv = 0;
      for (int i = 0; i < nv; i++) begin
        sum += vec_errs(i);
        if (vec_errs(i) != 0) efv |= (1 << i);
      end
      e1 = (sum > 31) ? 31 : sum;
      e2 = (sum > 3) ? 3 : sum;
      check("m_busy1", busy1, mact);
      check("m_done1", done1, mdone);
      check("m_pass1", pass1, (mdone && e1 == 0) ? 1 : 0);
      check("m_a1", a1, ea);
      check("m_b1", b1, eb);
      check("m_err1", err1, e1);
      check("m_fv1", fv1, efv);
      check("m_busy2", busy2, mact);
      check("m_done2", done2, mdone);
      check("m_pass2", pass2, (mdone && e2 == 0) ? 1 : 0);
      check("m_a2", a2, ea);
      check("m_b2", b2, eb);
      check("m_err2", err2, e2);
      check("m_fv2", fv2, efv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the cycle index (start-sampling cycle = 0) in which done first shows.
  task automatic wait_done(input int init, output int cyc);
    cyc = init;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done1) begin
        cyc = cyc + 1;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_timeout", 0, 1);
    cyc = -1;
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 4; i++) fm[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_ab", {a1, b1}, 0);
    check("rst_err", err1, 0);
    @(posedge clk);
    #1;

    // 1: ideal gates
    pulse_start();
    wait_done(0, cyc);
    check("t1_latency", cyc, 13);
    check("t1_pass", pass1, 1);
    check("t1_err", err1, 0);
    check("t1_fv", fv1, 4'b0000);
    check("t1_ab", {a1, b1}, 2'b11);
    @(posedge clk);
    #1;

    // 2: nAorB stuck-at-0
    fm[3] = 1;
    pulse_start();
    wait_done(0, cyc);
    check("t2_latency", cyc, 13);
    check("t2_err", err1, 1);
    check("t2_fv", fv1, 4'b0001);
    check("t2_pass", pass1, 0);
    @(posedge clk);
    #1;

    // 3: nAandB inverted
    fm[3] = 0;
    fm[1] = 2;
    pulse_start();
    wait_done(0, cyc);
    check("t3_err", err1, 4);
    check("t3_fv", fv1, 4'b1111);
    check("t3_err_w2", err2, 3);
    @(posedge clk);
    #1;

    // 4: restart attempt during vec 1 drive
    fm[1] = 0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, cyc);
    check("t4_latency", cyc, 13);
    check("t4_pass", pass1, 1);
    check("t4_fv", fv1, 4'b0000);
    @(posedge clk);
    #1;

    // 5: reset while vec = 2
    fm[0] = 2;
    pulse_start();
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy1, 0);
    check("t5_done", done1, 0);
    check("t5_ab", {a1, b1}, 0);
    check("t5_err", err1, 0);
    @(posedge clk);
    #1;
    fm[0] = 0;
    pulse_start();
    wait_done(0, cyc);
    check("t5_latency", cyc, 13);
    check("t5_pass", pass1, 1);
    @(posedge clk);
    #1;

    // 6: all outputs inverted -> 16 mismatches, saturating in the narrow instance
    for (int i = 0; i < 4; i++) fm[i] = 2;
    pulse_start();
    wait_done(0, cyc);
    check("t6_err_w5", err1, 16);
    check("t6_err_w2", err2, 3);
    check("t6_fv_w2", fv2, 4'b1111);
    check("t6_pass_w2", pass2, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) fm[i] = 0;
    pulse_start();
    @(negedge clk);
    check("t6_rerun_busy", busy2, 1);
    check("t6_rerun_done", done2, 0);
    check("t6_rerun_err", err2, 0);
    check("t6_rerun_fv", fv2, 0);
    @(posedge clk);
    #1;
    wait_done(1, cyc);
    check("t6_latency", cyc, 13);
    check("t6_rerun_pass", pass2, 1);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
